// File: rtl/digit_counter_if.sv
// Bundle of request and status signals for one digit of the alarm-clock time chain.
// The master drives the count/set requests; the slave is the digit counter itself.
interface digit_counter_if #(
  parameter int WIDTH = 4
);
  logic             inc;
  logic             dec;
  logic             set;
  logic [WIDTH-1:0] new_val;
  logic             clear_err;
  logic [WIDTH-1:0] Q;
  logic             at_max;
  logic             at_min;
  logic             carry;
  logic             borrow;
  logic             set_err;

  modport master (
    output inc, dec, set, new_val, clear_err,
    input  Q, at_max, at_min, carry, borrow, set_err
  );

  modport slave (
    input  inc, dec, set, new_val, clear_err,
    output Q, at_max, at_min, carry, borrow, set_err
  );
endinterface

// File: rtl/digit_counter_mod.sv
// Single-digit MIN_VAL..MAX_VAL up/down counter with wrap or saturate, cascade strobes and checked set.
// Define DIGIT_CARRY_REG_EN to register carry/borrow (one-cycle delay per cascade stage).
module digit_counter_mod #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 9,
  parameter int WRAP    = 1
) (
  input logic             clk,
  input logic             reset,
  digit_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] MIN_V = MIN_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             set_err_r;
  logic             q_ge_min, q_le_max, nv_ge_min, nv_le_max;
  logic             q_legal, nv_ok;
  logic             at_max, at_min;
  logic             step_inc, step_dec;
  logic             carry_c, borrow_c;

  // Bounds at the ends of the code space would be constant compares; tie them off instead.
  if (MIN_VAL == 0) begin : g_min_zero
    assign q_ge_min  = 1'b1;
    assign nv_ge_min = 1'b1;
  end else begin : g_min_cmp
    assign q_ge_min  = (q_r >= MIN_V);
    assign nv_ge_min = (bus.new_val >= MIN_V);
  end

  if (MAX_VAL == (2 ** WIDTH) - 1) begin : g_max_top
    assign q_le_max  = 1'b1;
    assign nv_le_max = 1'b1;
  end else begin : g_max_cmp
    assign q_le_max  = (q_r <= MAX_V);
    assign nv_le_max = (bus.new_val <= MAX_V);
  end

  assign q_legal = q_ge_min & q_le_max;
  assign nv_ok   = nv_ge_min & nv_le_max;
  assign at_max  = (q_r == MAX_V);
  assign at_min  = (q_r == MIN_V);

  assign step_inc = bus.inc & ~bus.dec & ~bus.set & ~reset;
  assign step_dec = bus.dec & ~bus.inc & ~bus.set & ~reset;
  // at_max/at_min are never true for an illegal Q, so the recovery step emits no strobe.
  assign carry_c  = step_inc & at_max;
  assign borrow_c = step_dec & at_min;

  always_comb begin
    q_next = q_r;
    if (bus.set) begin
      if (nv_ok) q_next = bus.new_val;
    end else if (step_inc || step_dec) begin
      if (!q_legal) begin
        q_next = MIN_V;
      end else if (step_inc) begin
        if (!at_max)        q_next = q_r + WIDTH'(1);
        else if (WRAP != 0) q_next = MIN_V;
      end else begin
        if (!at_min)        q_next = q_r - WIDTH'(1);
        else if (WRAP != 0) q_next = MAX_V;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r       <= MIN_V;
      set_err_r <= 1'b0;
    end else begin
      q_r <= q_next;
      if (bus.set && !nv_ok) set_err_r <= 1'b1;
      else if (bus.clear_err) set_err_r <= 1'b0;
    end
  end

`ifdef DIGIT_CARRY_REG_EN
  logic carry_r, borrow_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      carry_r  <= carry_c;
      borrow_r <= borrow_c;
    end
  end

  assign bus.carry  = carry_r;
  assign bus.borrow = borrow_r;
`else
  assign bus.carry  = carry_c;
  assign bus.borrow = borrow_c;
`endif

  assign bus.Q       = q_r;
  assign bus.at_max  = at_max;
  assign bus.at_min  = at_min;
  assign bus.set_err = set_err_r;
endmodule

// File: tb/tb_digit_counter_mod.sv
// Directed bench for digit_counter_mod: decimal digit, 1..12 hour digit and a saturating digit.
// Expected results are queued when each step is driven and checked when the DUT responds.
module tb_digit_counter_mod;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  digit_counter_if #(.WIDTH(4)) bus_a ();
  digit_counter_if #(.WIDTH(4)) bus_b ();
  digit_counter_if #(.WIDTH(4)) bus_c ();

  digit_counter_mod #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(1)) u_dec (
    .clk(clk), .reset(rst_a), .bus(bus_a));
  digit_counter_mod #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .WRAP(1)) u_hour (
    .clk(clk), .reset(rst_b), .bus(bus_b));
  digit_counter_mod #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(0)) u_sat (
    .clk(clk), .reset(rst_c), .bus(bus_c));

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] q;
    logic       carry;
    logic       borrow;
    logic       set_err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   min_v[3] = '{0, 1, 0};
  int   max_v[3] = '{9, 12, 9};

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rst, input logic inc, input logic dec,
                       input logic set, input logic [3:0] nv, input logic clr);
    rst_a = 1'b0; bus_a.inc = 1'b0; bus_a.dec = 1'b0; bus_a.set = 1'b0; bus_a.clear_err = 1'b0;
    rst_b = 1'b0; bus_b.inc = 1'b0; bus_b.dec = 1'b0; bus_b.set = 1'b0; bus_b.clear_err = 1'b0;
    rst_c = 1'b0; bus_c.inc = 1'b0; bus_c.dec = 1'b0; bus_c.set = 1'b0; bus_c.clear_err = 1'b0;
    case (sel)
      0: begin rst_a = rst; bus_a.inc = inc; bus_a.dec = dec; bus_a.set = set;
               bus_a.new_val = nv; bus_a.clear_err = clr; end
      1: begin rst_b = rst; bus_b.inc = inc; bus_b.dec = dec; bus_b.set = set;
               bus_b.new_val = nv; bus_b.clear_err = clr; end
      default: begin rst_c = rst; bus_c.inc = inc; bus_c.dec = dec; bus_c.set = set;
               bus_c.new_val = nv; bus_c.clear_err = clr; end
    endcase
  endtask

  task automatic read(input int sel, output logic [3:0] q, output logic c, output logic b,
                      output logic e, output logic amax, output logic amin);
    case (sel)
      0: begin q = bus_a.Q; c = bus_a.carry; b = bus_a.borrow; e = bus_a.set_err;
               amax = bus_a.at_max; amin = bus_a.at_min; end
      1: begin q = bus_b.Q; c = bus_b.carry; b = bus_b.borrow; e = bus_b.set_err;
               amax = bus_b.at_max; amin = bus_b.at_min; end
      default: begin q = bus_c.Q; c = bus_c.carry; b = bus_c.borrow; e = bus_c.set_err;
               amax = bus_c.at_max; amin = bus_c.at_min; end
    endcase
  endtask

  // Strobes are checked during the step cycle (combinational build) or just after its edge (registered build).
  task automatic step(input int sel, input logic rst, input logic inc, input logic dec,
                      input logic set, input logic [3:0] nv, input logic clr, input string tag,
                      input logic [3:0] eq, input logic ec, input logic eb, input logic ee);
    exp_t       e;
    logic [3:0] q;
    logic       c, b, se, amax, amin;
    e.tag = tag; e.sel = sel; e.q = eq; e.carry = ec; e.borrow = eb; e.set_err = ee;
    drive(sel, rst, inc, dec, set, nv, clr);
    sb.push_back(e);
    @(negedge clk);
`ifndef DIGIT_CARRY_REG_EN
    read(sel, q, c, b, se, amax, amin);
    check({tag, ".carry"}, {3'b0, c}, {3'b0, sb[0].carry});
    check({tag, ".borrow"}, {3'b0, b}, {3'b0, sb[0].borrow});
`endif
    @(posedge clk);
    #1;
    e = sb.pop_front();
    read(e.sel, q, c, b, se, amax, amin);
`ifdef DIGIT_CARRY_REG_EN
    check({e.tag, ".carry"}, {3'b0, c}, {3'b0, e.carry});
    check({e.tag, ".borrow"}, {3'b0, b}, {3'b0, e.borrow});
`endif
    check({e.tag, ".Q"}, q, e.q);
    check({e.tag, ".set_err"}, {3'b0, se}, {3'b0, e.set_err});
    check({e.tag, ".at_max"}, {3'b0, amax}, {3'b0, (int'(e.q) == max_v[e.sel])});
    check({e.tag, ".at_min"}, {3'b0, amin}, {3'b0, (int'(e.q) == min_v[e.sel])});
  endtask

  initial begin
    bus_a.new_val = 4'd0; bus_b.new_val = 4'd0; bus_c.new_val = 4'd0;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_b = 1'b1; rst_c = 1'b1;
    @(posedge clk);
    #1;

    // decimal digit: reset ignores inc, then a full count ring
    step(0, 1, 1, 0, 0, 4'd0, 0, "dec_rst", 4'd0, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      step(0, 0, 1, 0, 0, 4'd0, 0, $sformatf("dec_inc%0d", i), 4'(i % 10), (i == 10), 0, 0);

    step(0, 0, 0, 0, 1, 4'd3,  0, "set3",       4'd3, 0, 0, 0);
    step(0, 0, 1, 0, 1, 4'd11, 0, "set11_bad",  4'd3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 4'd0,  0, "err_sticky", 4'd3, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4'd5,  1, "set5_clr",   4'd5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd15, 1, "bad_clr",    4'd5, 0, 0, 1);
    step(0, 0, 0, 0, 0, 4'd0,  1, "clr_only",   4'd5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd9,  0, "set9",       4'd9, 0, 0, 0);
    step(0, 0, 1, 1, 0, 4'd0,  0, "inc_dec",    4'd9, 0, 0, 0);
    step(0, 0, 1, 0, 1, 4'd2,  0, "set2_inc",   4'd2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0,  0, "dec_2to1",   4'd1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0,  0, "dec_1to0",   4'd0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4'd0,  0, "dec_wrap",   4'd9, 0, 1, 0);
    step(0, 0, 1, 0, 0, 4'd0,  0, "inc_wrap",   4'd0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 4'd7,  0, "rst_set7",   4'd0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4'd0,  0, "set0_edge",  4'd0, 0, 0, 0);

    // hour digit 1..12
    step(1, 1, 0, 0, 0, 4'd0,  0, "hr_rst",     4'd1,  0, 0, 0);
    step(1, 0, 0, 1, 0, 4'd0,  0, "hr_dec",     4'd12, 0, 1, 0);
    step(1, 0, 1, 0, 0, 4'd0,  0, "hr_inc",     4'd1,  1, 0, 0);
    step(1, 0, 0, 0, 1, 4'd0,  0, "hr_set0",    4'd1,  0, 0, 1);
    step(1, 0, 0, 0, 1, 4'd13, 0, "hr_set13",   4'd1,  0, 0, 1);
    step(1, 0, 0, 0, 1, 4'd12, 1, "hr_set12",   4'd12, 0, 0, 0);

    // saturating digit
    step(2, 1, 0, 0, 0, 4'd0, 0, "sat_rst",  4'd0, 0, 0, 0);
    step(2, 0, 0, 0, 1, 4'd9, 0, "sat_set9", 4'd9, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(2, 0, 1, 0, 0, 4'd0, 0, $sformatf("sat_inc%0d", i), 4'd9, 1, 0, 0);
    step(2, 0, 0, 1, 0, 4'd0, 0, "sat_dec",  4'd8, 0, 0, 0);
    step(2, 0, 0, 0, 1, 4'd0, 0, "sat_set0", 4'd0, 0, 0, 0);
    step(2, 0, 0, 1, 0, 4'd0, 0, "sat_dec0", 4'd0, 0, 1, 0);
    step(2, 0, 1, 0, 0, 4'd0, 0, "sat_up",   4'd1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
